// File: rtl/apb_multi_slave_bridge_if.sv
// rtl/apb_multi_slave_bridge_if.sv - host command port and APB observation signals of the multi-slave bridge
interface apb_multi_slave_bridge_if #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 8,
    parameter int NUM_SLV = 2,
    parameter int WAIT_W  = 3
) ();
    logic                trans;
    logic                w_r;
    logic [ADDR_W-1:0]   apb_addr;
    logic [DATA_W-1:0]   apb_write_data;
    logic [WAIT_W-1:0]   wait_cfg;
    logic                ext_wait;
    logic                ext_pready;
    logic [DATA_W-1:0]   apb_read_data_out;
    logic                busy;
    logic                done;
    logic                err;
    logic [NUM_SLV-1:0]  psel_out;
    logic                penable_out;

    // Host / stimulus side: issues commands and the external ready.
    modport master (
        output trans, w_r, apb_addr, apb_write_data, wait_cfg, ext_wait, ext_pready,
        input  apb_read_data_out, busy, done, err, psel_out, penable_out
    );

    // Bridge side.
    modport slave (
        input  trans, w_r, apb_addr, apb_write_data, wait_cfg, ext_wait, ext_pready,
        output apb_read_data_out, busy, done, err, psel_out, penable_out
    );
endinterface

// File: rtl/apb_multi_slave_bridge.sv
// rtl/apb_multi_slave_bridge.sv - APB master FSM, decoder and NUM_SLV register-bank slaves; optional timeout under APB_TIMEOUT_EN
module apb_multi_slave_bridge #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int NUM_SLV   = 2,
    parameter int SLV_DEPTH = 16,
    parameter int WAIT_W    = 3,
    parameter int TIMEOUT   = 16
) (
    input  logic pclk,
    input  logic prst,
    apb_multi_slave_bridge_if.slave bus
);
    localparam int          OFF_W     = $clog2(SLV_DEPTH);
    localparam int          IDX_W     = ADDR_W - OFF_W;
    localparam logic [31:0] NUM_SLV_U = NUM_SLV;

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                wr_q, wr_d;
    logic [WAIT_W-1:0]   wcfg_q, wcfg_d;
    logic [WAIT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   mem_q [NUM_SLV][SLV_DEPTH];
    logic [DATA_W-1:0]   mem_d [NUM_SLV][SLV_DEPTH];

    logic [IDX_W-1:0]    slv_idx;
    logic [OFF_W-1:0]    slv_off;
    logic                dec_err;
    logic                ro_hit;
    logic [DATA_W-1:0]   rd_word;
    logic                int_pready;
    logic                eff_pready;
    logic                tout_hit;
    logic                complete;
    logic                take_cmd;
    logic [NUM_SLV-1:0]  psel;

    // Decode of the latched command address into bank index and word offset.
    assign slv_idx = addr_q[ADDR_W-1:OFF_W];
    assign slv_off = addr_q[OFF_W-1:0];
    assign dec_err = ({{(32-IDX_W){1'b0}}, slv_idx} >= NUM_SLV_U);
    assign ro_hit  = (slv_off == OFF_W'(SLV_DEPTH-1));

    // A decoded-out address has no slave to stall, so it is ready at once.
    assign int_pready = dec_err ? 1'b1 : (cnt_q == wcfg_q);
    assign eff_pready = bus.ext_wait ? bus.ext_pready : int_pready;

`ifdef APB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] tcnt_q, tcnt_d;

    // Give up on the TIMEOUT-th ACCESS cycle if no ready has arrived.
    assign tout_hit = !eff_pready && (tcnt_q == TO_W'(TIMEOUT - 1));

    // ACCESS-cycle counter: cleared in SETUP, counts through ACCESS.
    always_comb begin
        tcnt_d = tcnt_q;
        if (state_q == S_SETUP) begin
            tcnt_d = '0;
        end else if (state_q == S_ACCESS) begin
            tcnt_d = tcnt_q + 1'b1;
        end
    end

    // Timeout counter register.
    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            tcnt_q <= '0;
        end else begin
            tcnt_q <= tcnt_d;
        end
    end
`else
    // Without the timeout the transfer waits for ready indefinitely; TIMEOUT has no effect.
    assign tout_hit = (TIMEOUT < 0);
`endif

    assign complete = (state_q == S_ACCESS) && (eff_pready || tout_hit);
    assign take_cmd = bus.trans && ((state_q == S_IDLE) || complete);

    // Register-bank read mux for the latched address.
    always_comb begin
        rd_word = '0;
        for (int s = 0; s < NUM_SLV; s++) begin
            for (int o = 0; o < SLV_DEPTH; o++) begin
                if (slv_idx == IDX_W'(s) && slv_off == OFF_W'(o)) begin
                    rd_word = mem_q[s][o];
                end
            end
        end
    end

    // Next-state, command latch, completion response and bank writes.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        wcfg_d  = wcfg_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        mem_d   = mem_q;

        case (state_q)
            S_IDLE: begin
                if (bus.trans) begin
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                cnt_d   = '0;
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                cnt_d = cnt_q + 1'b1;
                if (complete) begin
                    done_d  = 1'b1;
                    state_d = bus.trans ? S_SETUP : S_IDLE;
                    if (tout_hit || dec_err) begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else if (wr_q) begin
                        if (ro_hit) begin
                            err_d = 1'b1;
                        end else begin
                            for (int s = 0; s < NUM_SLV; s++) begin
                                for (int o = 0; o < SLV_DEPTH; o++) begin
                                    if (slv_idx == IDX_W'(s) && slv_off == OFF_W'(o)) begin
                                        mem_d[s][o] = wdata_q;
                                    end
                                end
                            end
                        end
                    end else begin
                        rdata_d = ro_hit ? DATA_W'(slv_idx) : rd_word;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (take_cmd) begin
            addr_d  = bus.apb_addr;
            wdata_d = bus.apb_write_data;
            wr_d    = bus.w_r;
            wcfg_d  = bus.wait_cfg;
        end
    end

    // State, command and response registers; reset aborts any transfer.
    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            wcfg_q  <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            wcfg_q  <= wcfg_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Slave register banks.
    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            for (int s = 0; s < NUM_SLV; s++) begin
                for (int o = 0; o < SLV_DEPTH; o++) begin
                    mem_q[s][o] <= '0;
                end
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // One-hot select held from SETUP through completion; empty on decode error.
    always_comb begin
        psel = '0;
        for (int s = 0; s < NUM_SLV; s++) begin
            if (state_q != S_IDLE && !dec_err && slv_idx == IDX_W'(s)) begin
                psel[s] = 1'b1;
            end
        end
    end

    assign bus.psel_out          = psel;
    assign bus.penable_out       = (state_q == S_ACCESS);
    assign bus.busy              = (state_q != S_IDLE);
    assign bus.done              = done_q;
    assign bus.err               = err_q;
    assign bus.apb_read_data_out = rdata_q;
endmodule

// File: tb/tb_apb_multi_slave_bridge.sv
// tb/tb_apb_multi_slave_bridge.sv - scoreboard bench for apb_multi_slave_bridge with a behavioural bank model
module tb_apb_multi_slave_bridge;
    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 8;
    localparam int NUM_SLV   = 2;
    localparam int SLV_DEPTH = 16;
    localparam int WAIT_W    = 3;
    localparam int TIMEOUT   = 16;

    typedef struct {
        logic               err;
        logic [DATA_W-1:0]  rdata;
        int                 cyc;
        logic [NUM_SLV-1:0] psel;
        int                 setup_cyc;
    } exp_t;

    logic pclk;
    logic prst;
    int   cyc;
    int   checks;
    int   errors;
    exp_t sbq[$];
    exp_t mon_e;

    logic [DATA_W-1:0] mdl_mem [NUM_SLV][SLV_DEPTH];
    logic [DATA_W-1:0] mdl_rd;

    apb_multi_slave_bridge_if #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_SLV(NUM_SLV), .WAIT_W(WAIT_W)
    ) bus ();

    apb_multi_slave_bridge #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_SLV(NUM_SLV),
        .SLV_DEPTH(SLV_DEPTH), .WAIT_W(WAIT_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .pclk(pclk),
        .prst(prst),
        .bus (bus.slave)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    initial cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected outcome of one transfer from the bank/decode rules; updates the model.
    function automatic exp_t predict(input bit w, input int addr, input int data,
                                     input int stall, input int i_edge);
        exp_t e;
        int   idx;
        int   off;
        idx         = addr / SLV_DEPTH;
        off         = addr % SLV_DEPTH;
        e.cyc       = i_edge + 2 + stall;
        e.setup_cyc = i_edge;
        e.psel      = (idx < NUM_SLV) ? NUM_SLV'(1 << idx) : '0;
        e.err       = 1'b0;
`ifdef APB_TIMEOUT_EN
        if (stall < 0 || stall >= TIMEOUT) begin
            e.cyc   = i_edge + 1 + TIMEOUT;
            e.err   = 1'b1;
            mdl_rd  = '0;
            e.rdata = mdl_rd;
            return e;
        end
`endif
        if (idx >= NUM_SLV) begin
            e.err  = 1'b1;
            mdl_rd = '0;
        end else if (w) begin
            if (off == SLV_DEPTH - 1) e.err = 1'b1;
            else mdl_mem[idx][off] = DATA_W'(data);
        end else begin
            mdl_rd = (off == SLV_DEPTH - 1) ? DATA_W'(idx) : mdl_mem[idx][off];
        end
        e.rdata = mdl_rd;
        return e;
    endfunction

    task automatic wait_until(input int target);
        while (cyc < target) begin
            @(posedge pclk);
            #1;
        end
    endtask

    task automatic wait_done();
        int b;
        b = 0;
        @(negedge pclk);
        while (!bus.done && b < 400) begin
            @(negedge pclk);
            b++;
        end
        checks++;
        if (!bus.done) begin
            errors++;
            $display("FAIL done_wait: no done within %0d cycles", b);
        end
        @(posedge pclk);
        #1;
    endtask

    task automatic model_reset();
        for (int s = 0; s < NUM_SLV; s++)
            for (int o = 0; o < SLV_DEPTH; o++)
                mdl_mem[s][o] = '0;
        mdl_rd = '0;
    endtask

    // Single transfer from idle; ext=1 releases ext_pready after n stalled ACCESS cycles (n<0: never).
    task automatic xfer(input bit w, input int addr, input int data, input int wcfg,
                        input bit ext, input int n);
        int i_edge;
        int stall;
        bus.trans          = 1'b1;
        bus.w_r            = w;
        bus.apb_addr       = ADDR_W'(addr);
        bus.apb_write_data = DATA_W'(data);
        bus.wait_cfg       = WAIT_W'(wcfg);
        bus.ext_wait       = ext;
        bus.ext_pready     = 1'b0;
        i_edge = cyc + 1;
        if (ext) stall = n;
        else stall = (addr / SLV_DEPTH >= NUM_SLV) ? 0 : wcfg;
        sbq.push_back(predict(w, addr, data, stall, i_edge));
        wait_until(i_edge);
        bus.trans = 1'b0;
        if (ext && n >= 0) begin
            wait_until(i_edge + 1 + n);
            bus.ext_pready = 1'b1;
        end
        wait_done();
        bus.ext_wait   = 1'b0;
        bus.ext_pready = 1'b0;
    endtask

    // Back-to-back transfers: trans held high, each new command sampled on the previous completing edge.
    task automatic b2b(input int n);
        int i_edge;
        int stall;
        int addr;
        int data;
        int wcfg;
        bit w;
        i_edge = cyc + 1;
        for (int k = 0; k < n; k++) begin
            addr = $urandom_range(0, 8'h2F);
            data = $urandom_range(0, 255);
            wcfg = $urandom_range(0, 3);
            w    = 1'($urandom_range(0, 1));
            bus.trans          = 1'b1;
            bus.w_r            = w;
            bus.apb_addr       = ADDR_W'(addr);
            bus.apb_write_data = DATA_W'(data);
            bus.wait_cfg       = WAIT_W'(wcfg);
            bus.ext_wait       = 1'b0;
            stall = (addr / SLV_DEPTH >= NUM_SLV) ? 0 : wcfg;
            sbq.push_back(predict(w, addr, data, stall, i_edge));
            wait_until(i_edge);
            i_edge = i_edge + 2 + stall;
        end
        bus.trans = 1'b0;
        wait_until(i_edge + 1);
    endtask

    // Monitor: pops an expectation on every done and checks SETUP select.
    always @(negedge pclk) begin
        if (!prst) begin
            if (bus.done) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("err", int'(bus.err), int'(mon_e.err));
                    chk("rdata", int'(bus.apb_read_data_out), int'(mon_e.rdata));
                    chk("done_cycle", cyc, mon_e.cyc);
                end
            end else if (bus.err) begin
                chk("err_without_done", 1, 0);
            end
            if (bus.busy && !bus.penable_out && sbq.size() > 0) begin
                chk("setup_psel", int'(bus.psel_out), int'(sbq[0].psel));
                chk("setup_cycle", cyc, sbq[0].setup_cyc);
            end
        end
    end

    initial begin
        int i_edge;
        checks = 0;
        errors = 0;
        model_reset();
        prst               = 1'b1;
        bus.trans          = 1'b0;
        bus.w_r            = 1'b0;
        bus.apb_addr       = '0;
        bus.apb_write_data = '0;
        bus.wait_cfg       = '0;
        bus.ext_wait       = 1'b0;
        bus.ext_pready     = 1'b0;
        wait_until(3);
        chk("rst_rdata", int'(bus.apb_read_data_out), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_err", int'(bus.err), 0);
        chk("rst_psel", int'(bus.psel_out), 0);
        chk("rst_penable", int'(bus.penable_out), 0);
        prst = 1'b0;
        wait_until(cyc + 2);

        xfer(1'b1, 8'h03, 8'h5A, 0, 1'b0, 0);
        xfer(1'b0, 8'h03, 0, 0, 1'b0, 0);
        xfer(1'b0, 8'h12, 0, 5, 1'b0, 0);
        xfer(1'b1, 8'h25, 8'hC3, 2, 1'b0, 0);
        xfer(1'b0, 8'h25, 0, 0, 1'b0, 0);
        xfer(1'b0, 8'h1F, 0, 0, 1'b0, 0);
        xfer(1'b1, 8'h1F, 8'hFF, 1, 1'b0, 0);
        xfer(1'b0, 8'h1F, 0, 0, 1'b0, 0);
        xfer(1'b0, 8'h03, 0, 0, 1'b1, 10);
`ifdef APB_TIMEOUT_EN
        xfer(1'b0, 8'h03, 0, 0, 1'b1, -1);
        xfer(1'b1, 8'h05, 8'h11, 0, 1'b1, -1);
        xfer(1'b0, 8'h05, 0, 0, 1'b0, 0);
`endif

        // Reset during ACCESS of a write: no done, banks cleared.
        bus.trans          = 1'b1;
        bus.w_r            = 1'b1;
        bus.apb_addr       = 8'h04;
        bus.apb_write_data = 8'h77;
        bus.wait_cfg       = 3'd5;
        i_edge = cyc + 1;
        wait_until(i_edge);
        bus.trans = 1'b0;
        wait_until(i_edge + 3);
        chk("pre_rst_penable", int'(bus.penable_out), 1);
        prst = 1'b1;
        #1;
        chk("mid_rst_busy", int'(bus.busy), 0);
        chk("mid_rst_penable", int'(bus.penable_out), 0);
        chk("mid_rst_psel", int'(bus.psel_out), 0);
        chk("mid_rst_done", int'(bus.done), 0);
        chk("mid_rst_rdata", int'(bus.apb_read_data_out), 0);
        model_reset();
        wait_until(cyc + 1);
        prst = 1'b0;
        wait_until(cyc + 1);
        xfer(1'b0, 8'h04, 0, 0, 1'b0, 0);

        for (int k = 0; k < 40; k++) begin
            xfer(1'($urandom_range(0, 1)), $urandom_range(0, 8'h2F), $urandom_range(0, 255),
                 $urandom_range(0, 7), ($urandom_range(0, 3) == 0), $urandom_range(0, 8));
        end
        for (int k = 0; k < 3; k++) begin
            b2b(5);
            wait_until(cyc + 1);
        end
        for (int a = 0; a < 2 * SLV_DEPTH; a++) begin
            xfer(1'b0, a, 0, 0, 1'b0, 0);
        end

        wait_until(cyc + 3);
        chk("scoreboard_empty", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
